// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Brief    : Iterative RV32M multiply/divide unit, one radix-2 step per cycle.
// Revision : 1.0
// ============================================================================
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             start,
    input  logic             flush,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] pa,
    input  logic [WIDTH-1:0] pb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);
    localparam int            C_CW   = $clog2(WIDTH) + 1;
    localparam logic [C_CW-1:0] C_LAST = C_CW'(WIDTH);
    localparam logic [C_CW-1:0] C_ONE  = C_CW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [C_CW-1:0]      r_count;
    logic [2:0]           r_op;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [2*WIDTH-1:0]   r_acc;
    logic                 r_neg;
    logic                 r_b_zero;
    logic                 r_busy;
    logic                 r_done;
    logic [WIDTH-1:0]     r_result;

    logic                 w_is_div;
    logic                 w_signed_a;
    logic                 w_signed_b;
    logic                 w_sign_a;
    logic                 w_sign_b;
    logic [WIDTH-1:0]     w_mag_a;
    logic [WIDTH-1:0]     w_mag_b;
    logic [WIDTH:0]       w_mul_sum;
    logic [2*WIDTH:0]     w_div_sh;
    logic [WIDTH:0]       w_div_diff;
    logic [2*WIDTH-1:0]   w_prod;
    logic [WIDTH-1:0]     w_quot;
    logic [WIDTH-1:0]     w_rem;
    logic [WIDTH-1:0]     w_fix_value;

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;

    assign w_is_div   = r_op[2];
    assign w_signed_a = (r_op == 3'b001) || (r_op == 3'b010) || (r_op == 3'b100) || (r_op == 3'b110);
    assign w_signed_b = (r_op == 3'b001) || (r_op == 3'b100) || (r_op == 3'b110);
    assign w_sign_a   = w_signed_a && r_a[WIDTH-1];
    assign w_sign_b   = w_signed_b && r_b[WIDTH-1];
    // Plain WIDTH-bit negate: the magnitude of the most negative value stays exact as unsigned.
    assign w_mag_a    = w_sign_a ? -r_a : r_a;
    assign w_mag_b    = w_sign_b ? -r_b : r_b;

    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : '0);
    assign w_div_sh   = {r_acc, 1'b0};
    assign w_div_diff = w_div_sh[2*WIDTH:WIDTH] - {1'b0, r_b};

    // Divide by zero keeps the all-ones quotient regardless of operand signs.
    assign w_prod = r_neg ? -r_acc : r_acc;
    assign w_quot = (r_neg && !r_b_zero) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem  = r_neg ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

    always_comb begin
        w_fix_value = '0;
        case (r_op)
            3'b000:          w_fix_value = w_prod[WIDTH-1:0];
            3'b001, 3'b010,
            3'b011:          w_fix_value = w_prod[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:  w_fix_value = w_quot;
            default:         w_fix_value = w_rem;
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (start && !flush) w_next_state = S_CALC;
            S_CALC:  if (flush) w_next_state = S_IDLE;
                     else if (r_count == C_LAST) w_next_state = S_FIX;
            S_FIX:   w_next_state = flush ? S_IDLE : S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            r_state <= w_next_state;
            r_busy  <= (w_next_state != S_IDLE);
            r_done  <= (w_next_state == S_DONE);
            if (r_state == S_FIX && w_next_state == S_DONE) begin
                r_result <= w_fix_value;
            end
        end
    end

    // Count 0 is the magnitude-conversion cycle; counts 1..WIDTH are the iterations.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_count  <= '0;
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_neg    <= 1'b0;
            r_b_zero <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_next_state == S_CALC) begin
                        r_op    <= op;
                        r_a     <= pa;
                        r_b     <= pb;
                        r_acc   <= '0;
                        r_count <= '0;
                    end
                end
                S_CALC: begin
                    r_count <= r_count + C_ONE;
                    if (r_count == '0) begin
                        r_a      <= w_mag_a;
                        r_b      <= w_mag_b;
                        r_acc    <= {{WIDTH{1'b0}}, (w_is_div ? w_mag_a : w_mag_b)};
                        r_neg    <= (w_is_div && r_op[1]) ? w_sign_a : (w_sign_a ^ w_sign_b);
                        r_b_zero <= (r_b == '0);
                    end else if (w_is_div) begin
                        if (!w_div_diff[WIDTH]) begin
                            r_acc <= {w_div_diff[WIDTH-1:0], w_div_sh[WIDTH-1:1], 1'b1};
                        end else begin
                            r_acc <= w_div_sh[2*WIDTH-1:0];
                        end
                    end else begin
                        r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_unit
// Brief    : Directed self-checking bench for muldiv_unit.
// Revision : 1.0
// ============================================================================
module tb_muldiv_unit;
    localparam int W   = 32;
    localparam int LAT = W + 2;

    logic         clk   = 1'b0;
    logic         n_rst = 1'b0;
    logic         start = 1'b0;
    logic         flush = 1'b0;
    logic [2:0]   op    = 3'd0;
    logic [W-1:0] pa    = '0;
    logic [W-1:0] pb    = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;

    int checks = 0;
    int errors = 0;
    int got;

    muldiv_unit #(.WIDTH(W)) dut (
        .CLK    (clk),
        .nRST   (n_rst),
        .start  (start),
        .flush  (flush),
        .op     (op),
        .pa     (pa),
        .pb     (pb),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one op, optionally pulse start mid-flight, and check latency and result.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp, input int pulse_at);
        int lat;
        op = o; pa = a; pb = b; start = 1'b1;
        tick;
        start = 1'b0;
        check({tag, "_busy"}, {31'b0, busy}, 32'd1);
        lat = -1;
        for (int k = 1; k <= LAT + 6 && lat < 0; k++) begin
            start = (k == pulse_at);
            if (start) op = ~o;
            pa = $urandom;
            pb = $urandom;
            tick;
            if (done) lat = k;
        end
        start = 1'b0;
        check({tag, "_lat"}, lat, LAT);
        check({tag, "_res"}, result, exp);
        tick;
        check({tag, "_end"}, {30'b0, busy, done}, 32'd0);
    endtask

    initial begin
        tick;
        tick;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_res", result, 32'd0);
        n_rst = 1'b1;
        tick;

        run_op("mul", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 0);

        // Reset ten cycles into a multiply.
        op = 3'b000; pa = 32'd9; pb = 32'd9; start = 1'b1;
        tick;
        start = 1'b0;
        repeat (9) tick;
        n_rst = 1'b0;
        tick;
        check("rstmid_busy", {31'b0, busy}, 32'd0);
        check("rstmid_done", {31'b0, done}, 32'd0);
        check("rstmid_res", result, 32'd0);
        n_rst = 1'b1;
        got = -1;
        for (int k = 0; k < LAT + 6 && got < 0; k++) begin
            tick;
            if (done) got = k;
        end
        check("rstmid_nodone", got, -1);

        run_op("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5);
        run_op("mulh",   3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 0);
        run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op("mulh_min", 3'b001, 32'h8000_0000, 32'd2, 32'hFFFF_FFFF, 0);
        run_op("div",    3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0);
        run_op("rem",    3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0);
        run_op("divu",   3'b101, 32'd100, 32'd7, 32'd14, 0);
        run_op("remu",   3'b111, 32'd100, 32'd7, 32'd2, 0);
        run_op("div0",   3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
        run_op("div0_neg", 3'b100, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 0);
        run_op("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
        run_op("removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 0);

        // Start held high through the whole op, including the done cycle.
        op = 3'b000; pa = 32'd6; pb = 32'd7; start = 1'b1;
        tick;
        pb = 32'd5;
        got = -1;
        for (int k = 1; k <= LAT + 6 && got < 0; k++) begin
            tick;
            if (done) got = k;
        end
        check("hold_lat", got, LAT);
        check("hold_res", result, 32'd42);
        tick;
        check("hold_idle", {31'b0, busy}, 32'd0);
        start = 1'b0;
        run_op("b2b", 3'b101, 32'd1000, 32'd33, 32'd30, 0);
        run_op("remu0", 3'b111, 32'd5, 32'd0, 32'd5, 0);

        // Flush twenty cycles in, with a competing start on the same edge.
        op = 3'b000; pa = 32'd6; pb = 32'd7; start = 1'b1;
        tick;
        start = 1'b0;
        repeat (19) tick;
        flush = 1'b1; start = 1'b1; op = 3'b101; pa = 32'd100; pb = 32'd7;
        tick;
        check("flush_busy", {31'b0, busy}, 32'd0);
        check("flush_done", {31'b0, done}, 32'd0);
        flush = 1'b0; start = 1'b0;
        tick;
        check("flush_nostart", {31'b0, busy}, 32'd0);
        got = -1;
        for (int k = 0; k < LAT + 6 && got < 0; k++) begin
            tick;
            if (done) got = k;
        end
        check("flush_nodone", got, -1);
        check("flush_res", result, 32'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
